burst_generator: RTL and testbench
==================================

# burst_generator

Parametrised successor to the 8-bit `generator` stimulus block.
- Produces a burst of `len` values, started by a one-cycle `start` pulse.
- Width, sequence mode, wrap limit and LFSR taps are configurable.
- Sits in test and pattern paths as a data source for downstream blocks.
- Exposes a `valid`/`en` consume protocol, a `wrap` marker and a `done` pulse.

## Interface
- `WIDTH`, 8: width of `count`, `seed` and `limit`.
- `LEN_W`, 16: width of `len` and of the internal remaining-values counter.
- `TAPS`, `8'hB8`: Galois LFSR feedback mask (WIDTH bits); default is maximal-length for WIDTH=8.
- `clk`  in  1  clock; single clock domain.
- `res`  in  1  synchronous, active-high reset.
- `en`  in  1  consume/advance; the current value is taken on any cycle with `valid` and `en` both high.
- `start`  in  1  burst start pulse; ignored unless the FSM is in IDLE.
- `mode`  in  2  0 UP, 1 DOWN, 2 LFSR, 3 HOLD; latched on start.
- `seed`  in  WIDTH  first value of the burst; latched on start.
- `limit`  in  WIDTH  wrap bound for UP/DOWN; latched on start.
- `len`  in  LEN_W  number of values in the burst; latched on start.
- `count`  out  WIDTH  current value.
- `valid`  out  1  high while in RUN.
- `wrap`  out  1  one-cycle pulse, high while `count` shows a wrapped value.
- `done`  out  1  one-cycle pulse after the burst completes.

## Operation
- FSM states: IDLE, RUN.
- IDLE + `start`, `len`≠0: go to RUN. Load `count`=`seed`, remaining=`len`, latch `mode` and `limit`.
- IDLE + `start`, `len`=0: stay in IDLE; `done` pulses next cycle; `count` is unchanged.
- RUN + `en`:
  - `count` takes its next value and remaining decrements.
  - If remaining was 1, go to IDLE and pulse `done`; `count` still takes its next value.
- RUN + !`en`: all state holds.
- `start` in RUN is ignored.
- UP: next = 0 if `count`==`limit` or `count`==all-ones, else `count`+1. Wrap when next is 0 by that rule.
- DOWN: next = `limit` if `count`==0, else `count`-1. Wrap on the `limit` reload.
- LFSR:
  - next = (`count`>>1) ^ (`count`[0] ? `TAPS` : 0).
  - A seed of 0 is replaced by 1 at load.
  - Wrap when next equals the loaded (substituted) seed.
- HOLD: next = `count`; remaining still decrements; no wrap.
- Arithmetic is modulo 2^WIDTH. The remaining counter never underflows.
- `wrap` is registered together with `count`, so it is high in the same cycle as the wrapped value.

## Timing
- Reset values:
  - FSM in IDLE.
  - `count`=0, `valid`=0, `wrap`=0, `done`=0.
  - Latched `mode`/`limit`/`len`/`seed` registers = 0.
- `res` mid-burst: the next cycle is IDLE with `count`=0, and no `done` pulse. `res` has priority over `start` and `en`.
- Start latency: `start` sampled at edge N gives `count`=seed and `valid`=1 after edge N.
- Throughput: one value per cycle while `en` is held high.
- `done` is high in the cycle after the last consume edge; `valid`=0 in that same cycle.
- A `start` sampled in the `done` cycle is accepted (the FSM is already IDLE).

## Configuration
- `GENERATOR_LFSR_EN` defined: LFSR mode is implemented as specified; `TAPS` is used.
- `GENERATOR_LFSR_EN` not defined:
  - No LFSR logic is synthesised and `TAPS` is unused.
  - `mode`=2 behaves exactly as HOLD, with no wrap.
  - Seed 0 is loaded as 0.

## Structure
- Package `generator_pkg` holds:
  - Mode constants MODE_UP/MODE_DOWN/MODE_LFSR/MODE_HOLD.
  - FSM state encoding ST_IDLE/ST_RUN.
  - Default `TAPS` value for WIDTH=8.
- Sub-module `generator_step`: purely combinational. Inputs: current value, mode, limit, seed. Outputs: next value and wrap flag. `burst_generator` holds the FSM and registers.

## Test plan
- Reset: hold `res` for 2 cycles -> `count`=0; `valid`, `wrap`, `done` all 0.
- UP, seed=FD, limit=FF, len=5, `en`=1 -> `count` FD,FE,FF,00,01; `wrap` high with 00 only; `done` pulses one cycle after 01; `valid` drops with `done`.
- DOWN, seed=02, limit=03, len=5 -> 02,01,00,03,02; `wrap` high with 03 only.
- LFSR, seed=00, len=256 (`GENERATOR_LFSR_EN` defined):
  - Sequence 01,B8,5C,2E,17,B3,...
  - 256th value is 01 with `wrap` high; no repeat before that.
  - Without the macro: `count` stays 00 for the whole burst.
- Stall/ignore: `en` low for 3 cycles mid-burst -> `count` and `valid` hold, and exactly `len` values are consumed. A `start` with different `seed` during RUN has no effect.
- Corner cases:
  - `len`=0 start -> `done` pulse next cycle, `valid` stays 0.
  - `res` asserted in the 3rd cycle of a len=10 burst -> IDLE with `count`=0 next cycle, and no `done` pulse.

Source files
------------

// File: rtl/generator_pkg.sv
// ============================================================================
// generator_pkg : shared mode/state constants for burst_generator
// Rev 1.0
// ============================================================================
`default_nettype none

package generator_pkg;

   typedef logic [1:0] mode_t;

   localparam mode_t MODE_UP   = 2'd0;
   localparam mode_t MODE_DOWN = 2'd1;
   localparam mode_t MODE_LFSR = 2'd2;
   localparam mode_t MODE_HOLD = 2'd3;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   // Maximal-length Galois feedback mask for an 8-bit register
   localparam logic [7:0] TAPS_DEFAULT_W8 = 8'hB8;

endpackage

`default_nettype wire

// File: rtl/generator_step.sv
// ============================================================================
// generator_step : combinational next-value / wrap computation per mode
// LFSR datapath present only when GENERATOR_LFSR_EN is defined.
// Rev 1.0
// ============================================================================
`default_nettype none

module generator_step
   import generator_pkg::*;
#(
   parameter int                 WIDTH = 8,
   parameter logic [WIDTH-1:0]   TAPS  = WIDTH'(TAPS_DEFAULT_W8)
) (
   input  logic [WIDTH-1:0] i_cur,
   input  mode_t            i_mode,
   input  logic [WIDTH-1:0] i_limit,
   input  logic [WIDTH-1:0] i_seed,
   output logic [WIDTH-1:0] o_next,
   output logic             o_wrap
);

`ifdef GENERATOR_LFSR_EN
   logic [WIDTH-1:0] w_lfsr;
   assign w_lfsr = (i_cur >> 1) ^ (i_cur[0] ? TAPS : '0);
`else
   // The seed only matters for LFSR wrap detection
   logic w_unused_seed;
   assign w_unused_seed = ^i_seed;
`endif

   always_comb begin
      o_next = i_cur;
      o_wrap = 1'b0;
      case (i_mode)
         MODE_UP: begin
            if ((i_cur == i_limit) || (i_cur == '1)) begin
               o_next = '0;
               o_wrap = 1'b1;
            end else begin
               o_next = i_cur + WIDTH'(1);
            end
         end
         MODE_DOWN: begin
            if (i_cur == '0) begin
               o_next = i_limit;
               o_wrap = 1'b1;
            end else begin
               o_next = i_cur - WIDTH'(1);
            end
         end
`ifdef GENERATOR_LFSR_EN
         MODE_LFSR: begin
            o_next = w_lfsr;
            o_wrap = (w_lfsr == i_seed);
         end
`endif
         default: begin
            o_next = i_cur;
            o_wrap = 1'b0;
         end
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/burst_generator.sv
// ============================================================================
// burst_generator : start-triggered burst source with UP/DOWN/LFSR/HOLD modes
// Optional LFSR mode enabled by defining GENERATOR_LFSR_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module burst_generator
   import generator_pkg::*;
#(
   parameter int                 WIDTH = 8,
   parameter int                 LEN_W = 16,
   parameter logic [WIDTH-1:0]   TAPS  = WIDTH'(TAPS_DEFAULT_W8)
) (
   input  logic             clk,
   input  logic             res,
   input  logic             en,
   input  logic             start,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] seed,
   input  logic [WIDTH-1:0] limit,
   input  logic [LEN_W-1:0] len,
   output logic [WIDTH-1:0] count,
   output logic             valid,
   output logic             wrap,
   output logic             done
);

   logic [0:0]       r_state;
   logic [WIDTH-1:0] r_count;
   logic             r_wrap;
   logic             r_done;
   mode_t            r_mode;
   logic [WIDTH-1:0] r_limit;
   logic [WIDTH-1:0] r_seed;
   logic [LEN_W-1:0] r_rem;

   logic [WIDTH-1:0] w_seed_load;
   logic [WIDTH-1:0] w_next;
   logic             w_wrap;

`ifdef GENERATOR_LFSR_EN
   // An all-zero LFSR state would lock up, so substitute 1
   assign w_seed_load = ((mode == MODE_LFSR) && (seed == '0)) ? WIDTH'(1) : seed;
`else
   assign w_seed_load = seed;
`endif

   generator_step #(
      .WIDTH (WIDTH),
      .TAPS  (TAPS)
   ) u_step (
      .i_cur   (r_count),
      .i_mode  (r_mode),
      .i_limit (r_limit),
      .i_seed  (r_seed),
      .o_next  (w_next),
      .o_wrap  (w_wrap)
   );

   always_ff @(posedge clk) begin
      if (res) begin
         r_state <= ST_IDLE;
         r_count <= '0;
         r_wrap  <= 1'b0;
         r_done  <= 1'b0;
         r_mode  <= MODE_UP;
         r_limit <= '0;
         r_seed  <= '0;
         r_rem   <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_wrap <= 1'b0;
               if (start) begin
                  if (len == '0) begin
                     r_done <= 1'b1;
                  end else begin
                     r_state <= ST_RUN;
                     r_count <= w_seed_load;
                     r_seed  <= w_seed_load;
                     r_mode  <= mode_t'(mode);
                     r_limit <= limit;
                     r_rem   <= len;
                  end
               end
            end
            ST_RUN: begin
               if (en) begin
                  r_count <= w_next;
                  r_wrap  <= w_wrap;
                  r_rem   <= r_rem - LEN_W'(1);
                  if (r_rem == LEN_W'(1)) begin
                     r_state <= ST_IDLE;
                     r_done  <= 1'b1;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign count = r_count;
   assign valid = (r_state == ST_RUN);
   assign wrap  = r_wrap;
   assign done  = r_done;

endmodule

`default_nettype wire

// File: tb/tb_burst_generator.sv
// ============================================================================
// tb_burst_generator : directed self-checking bench for burst_generator
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_burst_generator;

   logic        clk;
   logic        res;
   logic        en;
   logic        start;
   logic [1:0]  mode;
   logic [7:0]  seed;
   logic [7:0]  limit;
   logic [15:0] len;
   logic [7:0]  count;
   logic        valid;
   logic        wrap;
   logic        done;

   int n_vec;
   int n_err;

   burst_generator #(
      .WIDTH (8),
      .LEN_W (16),
      .TAPS  (8'hB8)
   ) dut (
      .clk   (clk),
      .res   (res),
      .en    (en),
      .start (start),
      .mode  (mode),
      .seed  (seed),
      .limit (limit),
      .len   (len),
      .count (count),
      .valid (valid),
      .wrap  (wrap),
      .done  (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_burst(input logic [1:0] m, input logic [7:0] s,
                              input logic [7:0] l, input logic [15:0] n);
      mode  = m;
      seed  = s;
      limit = l;
      len   = n;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic test_reset();
      res = 1'b1;
      tick();
      tick();
      n_vec++;
      if ({count, valid, wrap, done} !== {8'h00, 3'b000}) begin
         n_err++;
         $display("FAIL reset: count=%h v/w/d=%b%b%b, expected 00 000", count, valid, wrap, done);
      end
      res = 1'b0;
      tick();
   endtask

   task automatic test_up();
      logic [7:0] exp_c [5] = '{8'hFD, 8'hFE, 8'hFF, 8'h00, 8'h01};
      logic       exp_w [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      en = 1'b1;
      start_burst(2'd0, 8'hFD, 8'hFF, 16'd5);
      for (int i = 0; i < 5; i++) begin
         n_vec++;
         if (count !== exp_c[i] || wrap !== exp_w[i] || valid !== 1'b1 || done !== 1'b0) begin
            n_err++;
            $display("FAIL up[%0d]: count=%h wrap=%b valid=%b done=%b, expected %h %b 1 0",
                     i, count, wrap, valid, done, exp_c[i], exp_w[i]);
         end
         tick();
      end
      n_vec++;
      if (done !== 1'b1 || valid !== 1'b0) begin
         n_err++;
         $display("FAIL up_done: done=%b valid=%b, expected 1 0", done, valid);
      end
      tick();
      n_vec++;
      if (done !== 1'b0) begin
         n_err++;
         $display("FAIL up_done_pulse: done=%b, expected 0", done);
      end
   endtask

   task automatic test_down();
      logic [7:0] exp_c [5] = '{8'h02, 8'h01, 8'h00, 8'h03, 8'h02};
      logic       exp_w [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      en = 1'b1;
      start_burst(2'd1, 8'h02, 8'h03, 16'd5);
      for (int i = 0; i < 5; i++) begin
         n_vec++;
         if (count !== exp_c[i] || wrap !== exp_w[i] || valid !== 1'b1) begin
            n_err++;
            $display("FAIL down[%0d]: count=%h wrap=%b valid=%b, expected %h %b 1",
                     i, count, wrap, valid, exp_c[i], exp_w[i]);
         end
         tick();
      end
      n_vec++;
      if (done !== 1'b1 || valid !== 1'b0) begin
         n_err++;
         $display("FAIL down_done: done=%b valid=%b, expected 1 0", done, valid);
      end
      tick();
   endtask

   task automatic test_lfsr();
      logic [7:0] head [6] = '{8'h01, 8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3};
      en = 1'b1;
      start_burst(2'd2, 8'h00, 8'h00, 16'd256);
      for (int i = 0; i < 256; i++) begin
`ifdef GENERATOR_LFSR_EN
         if (i < 6) begin
            n_vec++;
            if (count !== head[i]) begin
               n_err++;
               $display("FAIL lfsr_seq[%0d]: count=%h, expected %h", i, count, head[i]);
            end
         end
         if (i == 255) begin
            n_vec++;
            if (count !== 8'h01 || wrap !== 1'b1) begin
               n_err++;
               $display("FAIL lfsr_wrap: count=%h wrap=%b, expected 01 1", count, wrap);
            end
         end else if (i > 0) begin
            n_vec++;
            if (count === 8'h01 || wrap !== 1'b0) begin
               n_err++;
               $display("FAIL lfsr_norepeat[%0d]: count=%h wrap=%b, expected not 01, wrap 0",
                        i, count, wrap);
            end
         end
`else
         n_vec++;
         if (count !== 8'h00 || wrap !== 1'b0 || head[0] !== 8'h01) begin
            n_err++;
            $display("FAIL lfsr_off[%0d]: count=%h wrap=%b, expected 00 0", i, count, wrap);
         end
`endif
         tick();
      end
      n_vec++;
      if (done !== 1'b1 || valid !== 1'b0) begin
         n_err++;
         $display("FAIL lfsr_done: done=%b valid=%b, expected 1 0", done, valid);
      end
      tick();
   endtask

   task automatic test_stall();
      en = 1'b1;
      start_burst(2'd0, 8'h10, 8'hFF, 16'd4);
      tick();
      tick();
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (i == 1) begin
            seed  = 8'h55;
            start = 1'b1;
         end
         tick();
         start = 1'b0;
         n_vec++;
         if (count !== 8'h12 || valid !== 1'b1 || done !== 1'b0) begin
            n_err++;
            $display("FAIL stall[%0d]: count=%h valid=%b done=%b, expected 12 1 0",
                     i, count, valid, done);
         end
      end
      en = 1'b1;
      tick();
      n_vec++;
      if (count !== 8'h13 || valid !== 1'b1) begin
         n_err++;
         $display("FAIL stall_resume: count=%h valid=%b, expected 13 1", count, valid);
      end
      tick();
      n_vec++;
      if (count !== 8'h14 || done !== 1'b1 || valid !== 1'b0) begin
         n_err++;
         $display("FAIL stall_done: count=%h done=%b valid=%b, expected 14 1 0",
                  count, done, valid);
      end
      tick();
   endtask

   task automatic test_len0();
      start_burst(2'd0, 8'hAA, 8'hFF, 16'd0);
      n_vec++;
      if (done !== 1'b1 || valid !== 1'b0 || count !== 8'h14) begin
         n_err++;
         $display("FAIL len0: done=%b valid=%b count=%h, expected 1 0 14", done, valid, count);
      end
      tick();
      n_vec++;
      if (done !== 1'b0 || valid !== 1'b0) begin
         n_err++;
         $display("FAIL len0_after: done=%b valid=%b, expected 0 0", done, valid);
      end
   endtask

   task automatic test_back_to_back();
      en = 1'b1;
      start_burst(2'd0, 8'h20, 8'hFF, 16'd2);
      tick();
      tick();
      n_vec++;
      if (done !== 1'b1 || count !== 8'h22) begin
         n_err++;
         $display("FAIL b2b_done: done=%b count=%h, expected 1 22", done, count);
      end
      start_burst(2'd0, 8'h30, 8'hFF, 16'd1);
      n_vec++;
      if (count !== 8'h30 || valid !== 1'b1 || done !== 1'b0) begin
         n_err++;
         $display("FAIL b2b_start: count=%h valid=%b done=%b, expected 30 1 0",
                  count, valid, done);
      end
      tick();
      n_vec++;
      if (count !== 8'h31 || done !== 1'b1 || valid !== 1'b0) begin
         n_err++;
         $display("FAIL b2b_end: count=%h done=%b valid=%b, expected 31 1 0",
                  count, done, valid);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      en = 1'b1;
      start_burst(2'd0, 8'h40, 8'hFF, 16'd10);
      tick();
      tick();
      n_vec++;
      if (count !== 8'h42 || valid !== 1'b1) begin
         n_err++;
         $display("FAIL resmid_pre: count=%h valid=%b, expected 42 1", count, valid);
      end
      res = 1'b1;
      start = 1'b1;
      tick();
      res   = 1'b0;
      start = 1'b0;
      n_vec++;
      if (count !== 8'h00 || valid !== 1'b0 || done !== 1'b0 || wrap !== 1'b0) begin
         n_err++;
         $display("FAIL resmid: count=%h v/w/d=%b%b%b, expected 00 000", count, valid, wrap, done);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         n_vec++;
         if (done !== 1'b0 || valid !== 1'b0) begin
            n_err++;
            $display("FAIL resmid_after[%0d]: done=%b valid=%b, expected 0 0", i, done, valid);
         end
      end
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      res   = 1'b1;
      en    = 1'b0;
      start = 1'b0;
      mode  = 2'd0;
      seed  = 8'h00;
      limit = 8'h00;
      len   = 16'd0;
      test_reset();
      test_up();
      test_down();
      test_lfsr();
      test_stall();
      test_len0();
      test_back_to_back();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
